// File: rtl/crc_sequencer.sv
// Feeds queued words into an external CRC generator: a small {last,data} FIFO
// in front of a job FSM that pulses crc_reset/crc_start and captures the result.
module crc_sequencer #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] word_in,
  input  logic                 last_in,
  input  logic                 orient_in,
  input  logic                 result_ack,
  input  logic                 abort,
  input  logic                 crc_ready,
  input  logic [WORD_SIZE-1:0] crc_data_out,
  output logic                 word_ready,
  output logic [WORD_SIZE-1:0] crc_data_in,
  output logic                 crc_reset,
  output logic                 crc_start,
  output logic                 crc_orient,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("crc_sequencer: DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {IDLE, RESET, START, WAIT, HOLD, DONE} state_t;

  state_t               state;
  logic                 wait_first;
  logic [WORD_SIZE:0]   mem [DEPTH];
  logic [PW-1:0]        head, tail;
  logic [CW-1:0]        count, count_after;
  logic                 push_ok, pop, head_last;

  // word_ready comes from the registered count only, so a pop cannot free a slot
  // for a push in the same cycle.
  assign word_ready  = (count != CW'(DEPTH));
  assign push_ok     = push && word_ready && !abort;
  assign pop         = (state == WAIT) && !wait_first && crc_ready && !abort && (count != '0);
  assign head_last   = mem[head][WORD_SIZE];
  assign count_after = count - CW'(1) + CW'(push_ok);
  assign crc_data_in = (count == '0) ? '0 : mem[head][WORD_SIZE-1:0];

  always_ff @(posedge CLK) begin
    if (push_ok) mem[tail] <= {last_in, word_in};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (abort) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (push && !word_ready) overflow <= 1'b1;
    end
  end

  // Outputs are registered alongside the state so each pulse lines up with its state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      wait_first <= 1'b0;
      crc_reset  <= 1'b0;
      crc_start  <= 1'b0;
      crc_orient <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      crc_reset <= 1'b0;
      crc_start <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        wait_first <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (count != '0) begin
            state      <= RESET;
            crc_reset  <= 1'b1;
            crc_orient <= orient_in;
            busy       <= 1'b1;
          end
          RESET: begin
            state     <= START;
            crc_start <= 1'b1;
          end
          START: begin
            state      <= WAIT;
            wait_first <= 1'b1;
          end
          WAIT: begin
            wait_first <= 1'b0;
            if (pop) begin
              if (head_last) begin
                state  <= DONE;
                result <= crc_data_out;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else if (count_after != '0) begin
                state     <= START;
                crc_start <= 1'b1;
              end else begin
                state <= HOLD;
              end
            end
          end
          HOLD: if (count != '0) begin
            state     <= START;
            crc_start <= 1'b1;
          end
          DONE: if (result_ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_crc_sequencer.sv
// Self-checking bench for crc_sequencer: a behavioural CRC generator with random
// latency, an event monitor, and a job-level reference model.
module tb_crc_sequencer;
  localparam int W = 32;
  localparam int D = 4;

  logic         CLK = 1'b0, nRST = 1'b0, push = 1'b0, last_in = 1'b0, orient_in = 1'b0;
  logic         result_ack = 1'b0, abort = 1'b0;
  logic         crc_ready;
  logic [W-1:0] word_in = '0;
  logic [W-1:0] crc_data_out = '0;
  logic         word_ready, crc_reset, crc_start, crc_orient, busy, done, overflow;
  logic [W-1:0] crc_data_in, result;
  int           checks = 0, failures = 0;

  crc_sequencer #(.WORD_SIZE(W), .DEPTH(D)) dut (
    .CLK(CLK), .nRST(nRST), .push(push), .word_in(word_in), .last_in(last_in),
    .orient_in(orient_in), .result_ack(result_ack), .abort(abort), .crc_ready(crc_ready),
    .crc_data_out(crc_data_out), .word_ready(word_ready), .crc_data_in(crc_data_in),
    .crc_reset(crc_reset), .crc_start(crc_start), .crc_orient(crc_orient), .busy(busy),
    .done(done), .result(result), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Generator model: folds each started word into acc; ready after a latency.
  int           lat = 0, gen_lat = -1;
  bit           gen_hold = 1'b0;
  logic [W-1:0] acc = '0;
  int           n_reset = 0, n_start = 0;
  logic [W-1:0] start_q[$], done_q[$];
  logic         orient_q[$];
  logic         done_prev = 1'b0;

  assign crc_ready = (lat == 0) && !gen_hold;

  function automatic logic [W-1:0] mix(input logic [W-1:0] a, input logic [W-1:0] d);
    return {a[W-2:0], a[W-1]} ^ (d + 32'h9E37_79B9);
  endfunction

  always @(negedge CLK) begin
    if (crc_reset) begin
      acc     <= '0;
      n_reset <= n_reset + 1;
    end
    if (crc_start) begin
      acc          <= mix(acc, crc_data_in);
      crc_data_out <= mix(acc, crc_data_in);
      n_start      <= n_start + 1;
      start_q.push_back(crc_data_in);
      lat <= (gen_lat >= 0) ? gen_lat : int'($urandom_range(0, 3));
    end else if (lat > 0) begin
      lat <= lat - 1;
    end
    if (done && !done_prev) begin
      done_q.push_back(result);
      orient_q.push_back(crc_orient);
    end
    done_prev <= done;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = done;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic ack();
    result_ack = 1'b1;
    step(1);
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if ({word_ready, busy, done, overflow, crc_reset, crc_start, crc_orient} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_flags: got %b want %b",
               {word_ready, busy, done, overflow, crc_reset, crc_start, crc_orient}, 7'b1000000);
    end
    checks++;
    if (result !== '0 || crc_data_in !== '0) begin
      failures++;
      $display("FAIL reset_data: result=%h data_in=%h want 0", result, crc_data_in);
    end
    nRST = 1'b1;
    step(1);
    checks++;
    if (busy !== 1'b0 || word_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle: busy=%b word_ready=%b want 0/1", busy, word_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0]   expv [6];
    logic [W-1:0] exp;
    exp  = mix('0, 32'hDEAD_BEEF);
    expv = '{4'b0000, 4'b1010, 4'b0110, 4'b0010, 4'b0010, 4'b0001};
    gen_lat = 2; orient_in = 1'b1;
    word_in = 32'hDEAD_BEEF; last_in = 1'b1; push = 1'b1;
    step(1);
    push = 1'b0; last_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step(1);
      checks++;
      if ({crc_reset, crc_start, busy, done} !== expv[c]) begin
        failures++;
        $display("FAIL single_cycle%0d {reset,start,busy,done}: got %b want %b",
                 c, {crc_reset, crc_start, busy, done}, expv[c]);
      end
      if (c == 1) begin
        checks++;
        if (crc_orient !== 1'b1) begin
          failures++; $display("FAIL single_orient: got %b want 1", crc_orient);
        end
      end
      if (c == 2) begin
        checks++;
        if (crc_data_in !== 32'hDEAD_BEEF) begin
          failures++; $display("FAIL single_data_in: got %h want deadbeef", crc_data_in);
        end
      end
      if (c == 5) begin
        checks++;
        if (result !== exp) begin
          failures++; $display("FAIL single_result: got %h want %h", result, exp);
        end
      end
    end
    orient_in = 1'b0;
    ack();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      failures++;
      $display("FAIL single_after_ack: done=%b busy=%b result=%h want 0/0/%h", done, busy, result, exp);
    end
    gen_lat = -1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w [3];
    logic [W-1:0] exp;
    logic         ori;
    int           r0, s0, d0;
    bit           ok;
    exp = '0; r0 = n_reset; s0 = start_q.size(); d0 = done_q.size();
    ori = 1'($urandom); orient_in = ori;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom; exp = mix(exp, w[i]);
      word_in = w[i]; last_in = (i == 2); push = 1'b1;
      step(1);
    end
    push = 1'b0; last_in = 1'b0;
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_done_timeout: got no done want done"); end
    checks++;
    if (result !== exp) begin failures++; $display("FAIL b2b_result: got %h want %h", result, exp); end
    checks++;
    if (n_reset - r0 != 1 || start_q.size() - s0 != 3) begin
      failures++;
      $display("FAIL b2b_pulses: resets=%0d starts=%0d want 1/3", n_reset - r0, start_q.size() - s0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (start_q[s0+i] !== w[i]) begin
          failures++; $display("FAIL b2b_start_data%0d: got %h want %h", i, start_q[s0+i], w[i]);
        end
      end
    end
    ack();
    step(3);
    checks++;
    if (done_q.size() - d0 != 1 || orient_q[orient_q.size()-1] !== ori) begin
      failures++;
      $display("FAIL b2b_done_count: dones=%0d orient=%b want 1/%b", done_q.size() - d0,
               orient_q[orient_q.size()-1], ori);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] w [5];
    logic [W-1:0] exp;
    int           s0;
    bit           ok;
    exp = '0; s0 = start_q.size();
    gen_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      if (i < 4) exp = mix(exp, w[i]);
      word_in = w[i]; last_in = (i == 3); push = 1'b1;
      step(1);
      if (i == 3) begin
        checks++;
        if (word_ready !== 1'b0 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_full: word_ready=%b overflow=%b want 0/0", word_ready, overflow);
        end
      end
      if (i == 4) begin
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      end
    end
    push = 1'b0; last_in = 1'b0;
    gen_hold = 1'b0;
    wait_done(100, ok);
    checks++;
    if (!ok || result !== exp) begin
      failures++; $display("FAIL ovf_result: done=%b result=%h want 1/%h", ok, result, exp);
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ack();
    step(4);
    checks++;
    if (start_q.size() - s0 != 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_dropped_word: starts=%0d busy=%b want 4/0", start_q.size() - s0, busy);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (start_q[s0+i] !== w[i]) begin
          failures++; $display("FAIL ovf_start_data%0d: got %h want %h", i, start_q[s0+i], w[i]);
        end
      end
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_abort_clear: got %b want 0", overflow); end
  endtask

  task automatic test_hold();
    logic [W-1:0] w0, w1;
    int           r0, s0;
    bit           ok;
    w0 = $urandom; w1 = $urandom; r0 = n_reset; s0 = start_q.size();
    word_in = w0; last_in = 1'b0; push = 1'b1;
    step(1);
    push = 1'b0;
    step(10);
    checks++;
    if (busy !== 1'b1 || crc_start !== 1'b0 || done !== 1'b0 || start_q.size() - s0 != 1) begin
      failures++;
      $display("FAIL hold_wait: busy=%b start=%b done=%b starts=%0d want 1/0/0/1",
               busy, crc_start, done, start_q.size() - s0);
    end
    ack();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL hold_ack_ignored: busy=%b done=%b want 1/0", busy, done);
    end
    word_in = w1; last_in = 1'b1; push = 1'b1;
    step(1);
    push = 1'b0; last_in = 1'b0;
    wait_done(100, ok);
    checks++;
    if (!ok || result !== mix(mix('0, w0), w1)) begin
      failures++; $display("FAIL hold_result: done=%b result=%h want 1/%h", ok, result, mix(mix('0, w0), w1));
    end
    checks++;
    if (n_reset - r0 != 1 || start_q.size() - s0 != 2) begin
      failures++;
      $display("FAIL hold_pulses: resets=%0d starts=%0d want 1/2", n_reset - r0, start_q.size() - s0);
    end else begin
      checks++;
      if (start_q[s0+1] !== w1) begin
        failures++; $display("FAIL hold_second_data: got %h want %h", start_q[s0+1], w1);
      end
    end
    ack();
  endtask

  task automatic test_abort();
    int r0, s0;
    gen_hold = 1'b1;
    word_in = $urandom; last_in = 1'b0; push = 1'b1;
    step(1);
    word_in = $urandom; last_in = 1'b1;
    step(1);
    push = 1'b0; last_in = 1'b0;
    step(2);
    checks++;
    if (busy !== 1'b1 || word_ready !== 1'b1) begin
      failures++; $display("FAIL abort_pre: busy=%b word_ready=%b want 1/1", busy, word_ready);
    end
    r0 = n_reset; s0 = n_start;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    checks++;
    if ({word_ready, busy, done} !== 3'b100 || crc_data_in !== '0) begin
      failures++;
      $display("FAIL abort_idle: {ready,busy,done}=%b data_in=%h want 100/0",
               {word_ready, busy, done}, crc_data_in);
    end
    gen_hold = 1'b0;
    step(8);
    checks++;
    if (n_reset != r0 || n_start != s0) begin
      failures++; $display("FAIL abort_no_pulses: resets=%0d starts=%0d want 0/0", n_reset - r0, n_start - s0);
    end
    word_in = $urandom; last_in = 1'b1; push = 1'b1; abort = 1'b1;
    step(1);
    push = 1'b0; abort = 1'b0; last_in = 1'b0;
    checks++;
    if (overflow !== 1'b0 || crc_data_in !== '0 || word_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_push_drop: overflow=%b data_in=%h ready=%b want 0/0/1", overflow, crc_data_in, word_ready);
    end
    step(5);
    checks++;
    if (n_reset != r0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_push_nojob: resets=%0d busy=%b want 0/0", n_reset - r0, busy);
    end
  endtask

  task automatic test_async_reset();
    int r0, s0;
    orient_in = 1'b1;
    word_in = $urandom; last_in = 1'b1; push = 1'b1;
    step(1);
    push = 1'b0; last_in = 1'b0; orient_in = 1'b0;
    step(2);
    checks++;
    if (crc_start !== 1'b1) begin failures++; $display("FAIL areset_pre_start: got %b want 1", crc_start); end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({word_ready, busy, done, overflow, crc_reset, crc_start, crc_orient} !== 7'b1000000) begin
      failures++;
      $display("FAIL areset_flags: got %b want %b",
               {word_ready, busy, done, overflow, crc_reset, crc_start, crc_orient}, 7'b1000000);
    end
    checks++;
    if (result !== '0 || crc_data_in !== '0) begin
      failures++; $display("FAIL areset_data: result=%h data_in=%h want 0/0", result, crc_data_in);
    end
    step(2);
    r0 = n_reset; s0 = n_start;
    nRST = 1'b1;
    step(6);
    checks++;
    if (n_reset != r0 || n_start != s0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL areset_job_lost: resets=%0d starts=%0d busy=%b done=%b want 0/0/0/0",
               n_reset - r0, n_start - s0, busy, done);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] jw[$];
    bit           jl[$];
    bit           jo [6];
    logic [W-1:0] jc [6];
    int           r0, s0, d0;
    bit           prod_to, ack_to;
    prod_to = 1'b0; ack_to = 1'b0;
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 4);
      jo[k] = 1'($urandom);
      jc[k] = '0;
      for (int i = 0; i < n; i++) begin
        logic [W-1:0] v;
        v = $urandom;
        jw.push_back(v);
        jl.push_back(i == n - 1);
        jc[k] = mix(jc[k], v);
      end
    end
    r0 = n_reset; s0 = start_q.size(); d0 = done_q.size();
    orient_in = jo[0];
    fork
      begin
        for (int i = 0; i < jw.size(); i++) begin
          int g, t;
          g = $urandom_range(0, 2);
          if (g > 0) step(g);
          t = 0;
          while (!word_ready && t < 300) begin step(1); t++; end
          if (!word_ready) begin prod_to = 1'b1; break; end
          word_in = jw[i]; last_in = jl[i]; push = 1'b1;
          step(1);
          push = 1'b0; last_in = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          bit ok;
          int g;
          wait_done(400, ok);
          if (!ok) begin ack_to = 1'b1; break; end
          g = $urandom_range(0, 3);
          if (g > 0) step(g);
          if (k < 5) orient_in = jo[k+1];
          ack();
        end
      end
    join
    step(3);
    checks++;
    if (prod_to || ack_to) begin
      failures++; $display("FAIL rand_timeout: producer=%b acker=%b want 0/0", prod_to, ack_to);
    end
    checks++;
    if (done_q.size() - d0 != 6 || n_reset - r0 != 6 || start_q.size() - s0 != jw.size()) begin
      failures++;
      $display("FAIL rand_counts: dones=%0d resets=%0d starts=%0d want 6/6/%0d",
               done_q.size() - d0, n_reset - r0, start_q.size() - s0, jw.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (done_q[d0+k] !== jc[k] || orient_q[d0+k] !== jo[k]) begin
          failures++;
          $display("FAIL rand_job%0d: result=%h orient=%b want %h/%b", k, done_q[d0+k], orient_q[d0+k], jc[k], jo[k]);
        end
      end
      for (int i = 0; i < jw.size(); i++) begin
        checks++;
        if (start_q[s0+i] !== jw[i]) begin
          failures++; $display("FAIL rand_start%0d: got %h want %h", i, start_q[s0+i], jw[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_hold();
    test_abort();
    test_async_reset();
    repeat (3) test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/crc_sequencer.md
CRC_SEQUENCER -- requirements
Module: crc_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 32, sets the width of the data word and of the CRC result.
REQ-002 Parameter DEPTH, default 4, sets the number of input FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 push  in  1  enqueue word_in/last_in; honoured only when word_ready=1.
REQ-006 word_in  in  WORD_SIZE  word to be CRC'd.
REQ-007 last_in  in  1  marks the final word of a job.
REQ-008 orient_in  in  1  job orientation; sampled at job launch.
REQ-009 result_ack  in  1  host consumed result; clears done.
REQ-010 abort  in  1  synchronous job cancel.
REQ-011 crc_ready  in  1  generator idle/complete.
REQ-012 crc_data_out  in  WORD_SIZE  generator result.
REQ-013 word_ready  out  1  FIFO not full.
REQ-014 crc_data_in  out  WORD_SIZE  FIFO head data, or 0 when the FIFO is empty.
REQ-015 crc_reset, crc_start  out  1 each  one-cycle generator pulses.
REQ-016 crc_orient  out  1  latched job orientation.
REQ-017 busy  out  1  high in every state except IDLE and DONE.
REQ-018 done  out  1  result valid.
REQ-019 result  out  WORD_SIZE  captured CRC.
REQ-020 overflow  out  1  sticky flag set by a push that was dropped.

Function
REQ-021 The FIFO SHALL store {last, data}; word_ready = !full; a push with word_ready=1 SHALL write at the tail; pointers SHALL wrap modulo DEPTH.
REQ-022 A push with word_ready=0 SHALL be dropped and SHALL set overflow; the FIFO contents SHALL be unchanged.
REQ-023 On a full FIFO, a pop in the same cycle SHALL NOT make word_ready high in that cycle; word_ready is derived from the registered count only.
REQ-024 The FSM SHALL have the states IDLE, RESET, START, WAIT, HOLD and DONE.
REQ-025 IDLE -> RESET when the FIFO is non-empty; on that transition orient_in SHALL be latched into crc_orient.
REQ-026 RESET: crc_reset=1 for exactly one cycle, then -> START.
REQ-027 START: crc_start=1 for exactly one cycle with crc_data_in = head, then -> WAIT.
REQ-028 WAIT: crc_ready SHALL be ignored in the first WAIT cycle; from the second WAIT cycle on, crc_ready=1 SHALL pop the head.
REQ-029 WAIT exit on that pop:
- popped last=1 -> DONE, with result <= crc_data_out.
- otherwise, FIFO non-empty after the pop -> START.
- otherwise -> HOLD.
REQ-030 HOLD -> START when the FIFO is non-empty; no crc_reset SHALL be issued.
REQ-031 DONE: done=1; result_ack -> IDLE at the next edge; pushes SHALL still be accepted; the next job SHALL launch from IDLE.
REQ-032 result SHALL hold its value until the next DONE capture or reset.
REQ-033 abort in any state SHALL do all of the following at the next edge: go to IDLE, flush the FIFO, clear done and overflow, and issue no pulses.
REQ-034 abort SHALL take priority over push in the same cycle; that push SHALL be dropped without setting overflow.
REQ-035 A push and a pop in the same cycle on a non-full FIFO SHALL both take effect, leaving the count unchanged.
REQ-036 result_ack outside DONE SHALL be ignored.
REQ-037 crc_start SHALL never be asserted while the FIFO is empty.

Reset
REQ-038 nRST low SHALL immediately force the following, independent of CLK:
- state IDLE and an empty FIFO;
- word_ready=1, busy=0, done=0, overflow=0;
- crc_reset=0, crc_start=0, crc_orient=0;
- result=0, crc_data_in=0.
REQ-039 Deassertion of nRST mid-job SHALL leave no pending pulses; the job is lost.

Verification
REQ-040 Push 0xDEADBEEF with last=1 and orient=1 at cycle 0; the generator raises crc_ready in the second WAIT cycle -> crc_reset at cycle 1, crc_start at cycle 2, done at cycle 5, result = crc_data_out, crc_orient=1.
REQ-041 Push three words (last on the third) back-to-back -> exactly one crc_reset and three crc_start pulses, data in push order, a single done.
REQ-042 Push 5 words with DEPTH=4 while crc_ready is held low -> word_ready=0 after the 4th push, the 5th push is dropped, overflow=1.
REQ-043 Push a word with last=0, wait 10 cycles, then push a word with last=1 -> the FSM sits in HOLD between them, the second word gets crc_start without crc_reset, then done.
REQ-044 Assert abort while in WAIT with 2 words queued -> the next cycle is IDLE with word_ready=1 and busy=0, and no further pulses follow.
REQ-045 Assert nRST during START -> crc_start drops asynchronously and all outputs take their REQ-038 values.
